wm_lfsr_generator: RTL
======================

// Module: wm_lfsr_generator
// PURPOSE
//   Parametrised keyed pseudo-random watermark symbol generator. A Fibonacci LFSR is
//   seeded from a secret key. It produces wm_len symbols of OUT_W bits over a
//   valid/ready stream into the embedding datapath. The block supports a configurable
//   polynomial, warm-up discard, backpressure and a 1-bit/multi-bit symbol mode.
// PARAMETERS
//   LFSR_W  8      LFSR / key width (>=3)
//   TAPS    8'hB8  feedback mask; bit i set => lfsr[i] in XOR feedback (x^8+x^6+x^5+x^4+1)
//   OUT_W   2      symbol width, 1..LFSR_W
//   LEN_W   16     width of symbol-count request
//   WARMUP  8      LFSR steps discarded after seeding (0 = none)
// PORTS
//   clk        in   1       rising-edge clock
//   rst        in   1       synchronous, active-high reset
//   start      in   1       request a run; accepted only in IDLE
//   key        in   LFSR_W  seed, sampled on accepted start
//   wm_len     in   LEN_W   number of symbols to emit, sampled on accepted start
//   wm_select  in   1       0: 1-bit symbols (upper bits 0); 1: full OUT_W-bit symbols; sampled on start
//   wm_ready   in   1       downstream accepts symbol
//   wm_valid   out  1       symbol on wm_data is valid
//   wm_data    out  OUT_W   watermark symbol
//   busy       out  1       high in any state except IDLE
//   done       out  1       one-cycle pulse at end of run
// BEHAVIOUR
//   Reset: state=IDLE, lfsr={LFSR_W{1'b1}}, count=0, wm_valid=0, wm_data=0, busy=0, done=0.
//   Reset overrides everything. Reset asserted mid-run aborts the run. No done pulse.
//   LFSR step: fb = ^(lfsr & TAPS); lfsr <= {lfsr[LFSR_W-2:0], fb}.
//   Seed: lfsr <= (key==0) ? all-ones : key (lock-up avoidance). Latch wm_len and wm_select. count <= 0.
//   Symbol (combinational from lfsr, registered mode bit):
//     wm_data[0] = lfsr[0].
//     wm_data[i] (i>=1) = sel ? lfsr[i]^lfsr[i-1] : 0.
//     wm_data is forced to 0 whenever wm_valid=0.
//   FSM:
//     IDLE: start=1 -> seed.
//       If wm_len==0, go to DONE.
//       Else, if WARMUP>0, go to WARM; otherwise go to RUN.
//       start=0 -> stay.
//     WARM: step LFSR every cycle, wm_valid=0.
//       Go to RUN after exactly WARMUP steps (warm counter clog2(WARMUP+1) bits).
//     RUN: wm_valid=1.
//       On wm_valid&&wm_ready: step LFSR, count++.
//       If count==len-1 at the transfer, go to DONE.
//       When wm_ready=0, lfsr, count and wm_data hold stable (AXI-style, no retraction).
//     DONE: wm_valid=0, done=1 for exactly one cycle, then IDLE.
//   Latency: first valid symbol appears WARMUP+1 cycles after the accepted start edge.
//     Throughput is 1 symbol/cycle with ready held high.
//   Ignored inputs: start outside IDLE is ignored. key/len/select changes mid-run have no effect.
//   start held high through DONE begins a new run only after IDLE is re-entered
//     (one IDLE cycle minimum between runs).
//   count wraps never: wm_len max = 2^LEN_W-1 symbols.
//   Period with default TAPS = 255 steps for any nonzero seed.
// TESTING
//   1. WARMUP=0, key=8'h01, wm_len=5, select=0, ready=1 -> wm_data 1,0,0,0,1.
//      Then done pulse 1 cycle after the 5th transfer.
//   2. Same with select=1 -> wm_data 2'b11,2'b10,2'b00,2'b00,2'b11.
//   3. Backpressure: ready toggled 1,0,0,1,... in case 2 -> identical symbol sequence.
//      wm_data is stable while valid&&!ready.
//   4. key=0, wm_len=256, WARMUP=0 -> first state 8'hFF.
//      Symbol 256 equals symbol 1 (period 255). No all-zero lfsr ever seen.
//   5. WARMUP=8, key=8'h01 -> wm_valid rises 9 cycles after start.
//      First symbol = lfsr[0] of state after 8 steps from 8'h01.
//   6. Edge cases:
//      - wm_len=0 -> no valid, done 1 cycle after start.
//      - rst mid-RUN -> next cycle IDLE, valid=0, no done.
//      - start during RUN ignored.

Source files
------------

// File: rtl/wm_lfsr_generator.sv
// Keyed pseudo-random watermark symbol generator.
// A Fibonacci LFSR seeded from a secret key produces wm_len symbols of OUT_W bits
// over a valid/ready stream, with optional warm-up discard after seeding and a
// 1-bit / multi-bit symbol mode selected per run.
module wm_lfsr_generator #(
    parameter int                LFSR_W = 8,
    parameter logic [LFSR_W-1:0] TAPS   = 8'hB8,
    parameter int                OUT_W  = 2,
    parameter int                LEN_W  = 16,
    parameter int                WARMUP = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LFSR_W-1:0] key,
    input  logic [LEN_W-1:0]  wm_len,
    input  logic              wm_select,
    input  logic              wm_ready,
    output logic              wm_valid,
    output logic [OUT_W-1:0]  wm_data,
    output logic              busy,
    output logic              done
);

    // Warm-up counter needs at least one bit even when warm-up is disabled.
    localparam int                WARM_W    = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'((WARMUP > 0) ? (WARMUP - 1) : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WARM,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state_q;
    logic [LFSR_W-1:0]  lfsr_q;
    logic [LFSR_W-1:0]  lfsr_d;
    logic [LFSR_W-1:0]  seed;
    logic [LEN_W-1:0]   count_q;
    logic [LEN_W-1:0]   len_q;
    logic               sel_q;
    logic [WARM_W-1:0]  warm_q;
    logic               valid_q;
    logic               done_q;
    logic               busy_q;
    logic [OUT_W-1:0]   sym;
    logic               xfer;
    logic               last_xfer;

    // An all-zero seed would lock the LFSR up, so it is replaced by all-ones.
    assign seed = (key == '0) ? '1 : key;

    assign xfer      = valid_q && wm_ready;
    assign last_xfer = (count_q == (len_q - LEN_W'(1)));

    // Next LFSR state: shift left, XOR of the tapped bits enters at bit 0.
    always_comb begin
        lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & TAPS)};
    end

    // Symbol from the current LFSR state; upper bits are neighbour XORs in full mode.
    always_comb begin
        // NOTE: every bit gets a default first so no latch is inferred for the
        // bits the loop may skip (OUT_W == 1) or the mode leaves untouched.
        sym    = '0;
        sym[0] = lfsr_q[0];
        for (int i = 1; i < OUT_W; i++) begin
            sym[i] = sel_q & (lfsr_q[i] ^ lfsr_q[i-1]);
        end
    end

    // Control FSM with registered stream and status outputs.
    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every register samples
        // the pre-edge values; blocking here would create order-dependent logic.
        if (rst) begin
            state_q <= S_IDLE;
            lfsr_q  <= '1;
            count_q <= '0;
            len_q   <= '0;
            sel_q   <= 1'b0;
            warm_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        lfsr_q  <= seed;
                        len_q   <= wm_len;
                        sel_q   <= wm_select;
                        count_q <= '0;
                        warm_q  <= '0;
                        busy_q  <= 1'b1;
                        if (wm_len == '0) begin
                            state_q <= S_DONE;
                        end else if (WARMUP > 0) begin
                            state_q <= S_WARM;
                        end else begin
                            state_q <= S_RUN;
                        end
                    end
                end
                S_WARM: begin
                    lfsr_q <= lfsr_d;
                    if (warm_q == WARM_LAST) begin
                        state_q <= S_RUN;
                    end else begin
                        warm_q <= warm_q + WARM_W'(1);
                    end
                end
                S_RUN: begin
                    // wm_valid is registered, so it rises one cycle after RUN is
                    // entered; after that the symbol only advances on a transfer.
                    if (!valid_q) begin
                        valid_q <= 1'b1;
                    end else if (xfer) begin
                        lfsr_q  <= lfsr_d;
                        count_q <= count_q + LEN_W'(1);
                        if (last_xfer) begin
                            valid_q <= 1'b0;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign wm_valid = valid_q;
    assign wm_data  = valid_q ? sym : '0;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
